// File: rtl/lcd_pkg.sv
// Shared constants and phase encoding for the HD44780 bus model
// and the controller FSMs that drive it.
package lcd_pkg;

    localparam int         ROW_LEN         = 40;
    localparam logic [6:0] DDRAM_ROW2_BASE = 7'h40;
    localparam logic [6:0] ROW1_LAST       = 7'h27;
    localparam logic [6:0] ROW2_LAST       = 7'h67;
    localparam logic [6:0] LINE_LAST       = 7'h4F;
    localparam logic [7:0] CHAR_SPACE      = 8'h20;

    localparam logic [7:0] OP_CLEAR     = 8'h01;
    localparam logic [7:0] OP_HOME      = 8'h02;
    localparam logic [7:0] OP_HOME_MASK = 8'hFE;

    typedef enum logic [1:0] {
        PH_INIT_FILL = 2'd0,
        PH_POWERON   = 2'd1,
        PH_READY     = 2'd2,
        PH_BUSY      = 2'd3
    } lcd_phase_e;

    function automatic logic [5:0] mod_row(input logic [5:0] v);
        return (v >= 6'(ROW_LEN)) ? v - 6'(ROW_LEN) : v;
    endfunction

    // DDRAM address -> physical slot in the 80-byte array
    function automatic logic [6:0] ddram_index(
        input logic [6:0] a,
        input logic       n
    );
        logic [6:0] base;
        base = a[6] ? 7'(ROW_LEN) : 7'd0;
        if (n)
            return base + {1'b0, mod_row(a[5:0])};
        return (a >= 7'(2 * ROW_LEN)) ? a - 7'(2 * ROW_LEN) : a;
    endfunction

endpackage

// File: rtl/lcd_ac_stepper.sv
// Next address-counter value for a +/-1 step, honouring the
// CGRAM, one-line and two-line DDRAM wrap points.
module lcd_ac_stepper
    import lcd_pkg::*;
(
    input  logic [6:0] i_ac,
    input  logic       i_up,
    input  logic       i_cgram,
    input  logic       i_two_line,
    output logic [6:0] o_ac
);

    always_comb begin
        o_ac = i_ac;
        if (i_cgram) begin
            o_ac = {1'b0, i_up ? i_ac[5:0] + 6'd1
                               : i_ac[5:0] - 6'd1};
        end else if (i_two_line) begin
            if (i_up)
                o_ac = (i_ac == ROW1_LAST) ? DDRAM_ROW2_BASE :
                       (i_ac == ROW2_LAST) ? 7'h00 :
                       i_ac + 7'd1;
            else
                o_ac = (i_ac == 7'h00) ? ROW2_LAST :
                       (i_ac == DDRAM_ROW2_BASE) ? ROW1_LAST :
                       i_ac - 7'd1;
        end else begin
            if (i_up)
                o_ac = (i_ac == LINE_LAST) ? 7'h00 : i_ac + 7'd1;
            else
                o_ac = (i_ac == 7'h00) ? LINE_LAST : i_ac - 7'd1;
        end
    end

endmodule

// File: rtl/hd44780_lcd_responder.sv
// HD44780-compatible display end of the 8-bit LCD bus: decodes
// transactions, models busy timing and exposes the visible text.
module hd44780_lcd_responder
    import lcd_pkg::*;
#(
    parameter int POWERON_CYCLES    = 500,
    parameter int CMD_BUSY_CYCLES   = 4,
    parameter int CLEAR_BUSY_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic       lcd_e,
    input  logic [7:0] lcd_data,
    output logic [7:0] lcd_dout,
    output logic       busy,
    output logic [6:0] ac,
    output logic       disp_on,
    output logic       cursor_on,
    output logic       blink_on,
    output logic       entry_id,
    output logic       entry_s,
    output logic       two_line,
    output logic       dl8,
    input  logic       rd_row,
    input  logic [3:0] rd_col,
    output logic [7:0] rd_char,
    output logic       wr_strobe,
    output logic       err_busy,
    output logic       err_early
);

    localparam logic [15:0] PON_LAST = 16'(POWERON_CYCLES - 1);
    localparam logic [7:0]  CMD_B    = 8'(CMD_BUSY_CYCLES);
    localparam logic [7:0]  CLR_B    = 8'(CLEAR_BUSY_CYCLES);

    logic       r_e_s1, r_e_s2, r_rs_d, r_rw_d;
    logic [7:0] r_data_d;
    logic       r_pend, r_t_rs, r_t_rw;
    logic [7:0] r_t_data;

    lcd_phase_e r_state, w_next;
    logic [15:0] r_pon_cnt;
    logic [7:0]  r_busy_cnt;

    logic [6:0] r_ac;
    logic       r_cg;
    logic [5:0] r_offset;
    logic       r_disp, r_cur, r_blink, r_id, r_s, r_n, r_dl;
    logic       r_err_busy, r_err_early, r_wr_strobe;
    logic [7:0] r_dout;

    logic [7:0] r_ddram [0:79];
    logic [4:0] r_cgram [0:63];

    logic       w_fall, w_busy, w_fill, w_early, w_legal;
    logic       w_cmd, w_wr_data, w_rd_data;
    logic       w_clear, w_home, w_start_busy, w_step_up;
    logic [6:0] w_ac_next, w_ac_idx, w_rd_idx;
    logic [5:0] w_off_inc, w_off_dec, w_rd_sum;
    logic [5:0] w_fill_idx;
    logic [7:0] w_rd_byte;

    // falling edge seen after the two-flop synchroniser
    assign w_fall       = !r_e_s1 && r_e_s2;
    assign w_legal      = r_pend && !w_early;
    assign w_cmd        = w_legal && !r_t_rs && !r_t_rw;
    assign w_wr_data    = w_legal && r_t_rs && !r_t_rw;
    assign w_rd_data    = w_legal && r_t_rs && r_t_rw;
    assign w_clear      = w_cmd && (r_t_data == OP_CLEAR);
    assign w_home       = w_cmd &&
                          ((r_t_data & OP_HOME_MASK) == OP_HOME);
    assign w_start_busy = w_legal && !r_t_rw;
    assign w_step_up    = w_cmd ? r_t_data[2] : r_id;

    assign w_off_inc = (r_offset == 6'(ROW_LEN - 1)) ?
                       6'd0 : r_offset + 6'd1;
    assign w_off_dec = (r_offset == 6'd0) ?
                       6'(ROW_LEN - 1) : r_offset - 6'd1;

    assign w_ac_idx  = ddram_index(r_ac, r_n);
    assign w_rd_byte = r_cg ? {3'b000, r_cgram[r_ac[5:0]]}
                            : r_ddram[w_ac_idx];
    assign w_fill_idx = r_pon_cnt[5:0];

    assign w_rd_sum = {2'b00, rd_col} + r_offset;
    assign w_rd_idx = ddram_index({rd_row, mod_row(w_rd_sum)}, r_n);
    assign rd_char  = r_disp ? r_ddram[w_rd_idx] : CHAR_SPACE;

    lcd_ac_stepper u_step (
        .i_ac       (r_ac),
        .i_up       (w_step_up),
        .i_cgram    (r_cg),
        .i_two_line (r_n),
        .o_ac       (w_ac_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= PH_INIT_FILL;
            r_pon_cnt  <= '0;
            r_busy_cnt <= '0;
        end else begin
            r_state <= w_next;
            if (w_early)
                r_pon_cnt <= r_pon_cnt + 16'd1;
            if (w_start_busy)
                r_busy_cnt <= (w_clear || w_home) ? CLR_B : CMD_B;
            else if (w_busy && r_busy_cnt != 8'd0)
                r_busy_cnt <= r_busy_cnt - 8'd1;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            PH_INIT_FILL:
                if (r_pon_cnt == 16'd63) w_next = PH_POWERON;
            PH_POWERON:
                if (r_pon_cnt == PON_LAST) w_next = PH_READY;
            PH_READY:
                if (w_start_busy) w_next = PH_BUSY;
            PH_BUSY:
                if (!w_start_busy && r_busy_cnt == 8'd1)
                    w_next = PH_READY;
            default: w_next = PH_INIT_FILL;
        endcase
    end

    always_comb begin
        w_busy  = (r_state == PH_BUSY);
        w_fill  = (r_state == PH_INIT_FILL);
        w_early = (r_state == PH_INIT_FILL) ||
                  (r_state == PH_POWERON);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_e_s1 <= 1'b0;  r_e_s2 <= 1'b0;
            r_rs_d <= 1'b0;  r_rw_d <= 1'b0;
            r_data_d <= '0;
            r_pend <= 1'b0;  r_t_rs <= 1'b0;
            r_t_rw <= 1'b0;  r_t_data <= '0;
            r_ac <= '0;  r_cg <= 1'b0;  r_offset <= '0;
            r_disp <= 1'b0;  r_cur <= 1'b0;  r_blink <= 1'b0;
            r_id <= 1'b1;  r_s <= 1'b0;
            r_n <= 1'b0;  r_dl <= 1'b1;
            r_err_busy <= 1'b0;  r_err_early <= 1'b0;
            r_wr_strobe <= 1'b0;  r_dout <= '0;
        end else begin
            r_e_s1   <= lcd_e;
            r_e_s2   <= r_e_s1;
            r_rs_d   <= lcd_rs;
            r_rw_d   <= lcd_rw;
            r_data_d <= lcd_data;
            r_pend   <= w_fall;
            if (w_fall) begin
                r_t_rs   <= r_rs_d;
                r_t_rw   <= r_rw_d;
                r_t_data <= r_data_d;
            end
            r_wr_strobe <= w_wr_data;
            if (r_pend && w_early) r_err_early <= 1'b1;
            if (r_pend && w_busy)  r_err_busy  <= 1'b1;
            if (r_e_s1 && r_rw_d)
                r_dout <= r_rs_d ? w_rd_byte : {w_busy, r_ac};

            if (w_cmd) begin
                unique casez (r_t_data)
                    8'b1???????: begin
                        r_ac <= r_t_data[6:0];
                        r_cg <= 1'b0;
                    end
                    8'b01??????: begin
                        r_ac <= {1'b0, r_t_data[5:0]};
                        r_cg <= 1'b1;
                    end
                    8'b001?????: begin
                        r_dl <= r_t_data[4];
                        r_n  <= r_t_data[3];
                    end
                    // R = 1 moves the text right, i.e. offset - 1
                    8'b0001????: begin
                        if (r_t_data[3])
                            r_offset <= r_t_data[2] ? w_off_dec
                                                    : w_off_inc;
                        else
                            r_ac <= w_ac_next;
                    end
                    8'b00001???: begin
                        r_disp  <= r_t_data[2];
                        r_cur   <= r_t_data[1];
                        r_blink <= r_t_data[0];
                    end
                    8'b000001??: begin
                        r_id <= r_t_data[1];
                        r_s  <= r_t_data[0];
                    end
                    8'b0000001?: begin
                        r_ac <= '0;  r_offset <= '0;
                        r_cg <= 1'b0;
                    end
                    8'b00000001: begin
                        r_ac <= '0;  r_offset <= '0;
                        r_cg <= 1'b0;  r_id <= 1'b1;
                    end
                    default: ;
                endcase
            end else if (w_wr_data) begin
                r_ac <= w_ac_next;
                if (r_s && !r_cg)
                    r_offset <= r_id ? w_off_inc : w_off_dec;
            end else if (w_rd_data) begin
                r_ac <= w_ac_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_fill) begin
            r_cgram[w_fill_idx] <= 5'd0;
            r_ddram[{1'b0, w_fill_idx}] <= CHAR_SPACE;
            if (w_fill_idx[5:4] == 2'b00)
                r_ddram[{1'b0, w_fill_idx} + 7'd64] <= CHAR_SPACE;
        end else if (w_clear) begin
            for (int i = 0; i < 80; i++)
                r_ddram[i] <= CHAR_SPACE;
        end else if (w_wr_data) begin
            if (r_cg)
                r_cgram[r_ac[5:0]] <= r_t_data[4:0];
            else
                r_ddram[w_ac_idx] <= r_t_data;
        end
    end

    assign lcd_dout  = r_dout;
    assign busy      = w_busy;
    assign ac        = r_ac;
    assign disp_on   = r_disp;
    assign cursor_on = r_cur;
    assign blink_on  = r_blink;
    assign entry_id  = r_id;
    assign entry_s   = r_s;
    assign two_line  = r_n;
    assign dl8       = r_dl;
    assign wr_strobe = r_wr_strobe;
    assign err_busy  = r_err_busy;
    assign err_early = r_err_early;

endmodule

// File: tb/tb_hd44780_lcd_responder.sv
// Bench for hd44780_lcd_responder: vector table, corner-case
// sequences and random traffic against a linear DDRAM model.
module tb_hd44780_lcd_responder;

    logic       clk = 1'b0;
    logic       rst;
    logic       lcd_rs, lcd_rw, lcd_e;
    logic [7:0] lcd_data;
    logic [7:0] lcd_dout;
    logic       busy;
    logic [6:0] ac;
    logic       disp_on, cursor_on, blink_on;
    logic       entry_id, entry_s, two_line, dl8;
    logic       rd_row;
    logic [3:0] rd_col;
    logic [7:0] rd_char;
    logic       wr_strobe, err_busy, err_early;

    hd44780_lcd_responder dut (
        .clk(clk), .rst(rst),
        .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e),
        .lcd_data(lcd_data), .lcd_dout(lcd_dout),
        .busy(busy), .ac(ac),
        .disp_on(disp_on), .cursor_on(cursor_on),
        .blink_on(blink_on), .entry_id(entry_id),
        .entry_s(entry_s), .two_line(two_line), .dl8(dl8),
        .rd_row(rd_row), .rd_col(rd_col), .rd_char(rd_char),
        .wr_strobe(wr_strobe), .err_busy(err_busy),
        .err_early(err_early)
    );

    always #5 clk = ~clk;

    int n_run = 0;
    int n_fail = 0;
    int strobes = 0;

    always @(negedge clk) if (wr_strobe) strobes++;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic       rs;
        logic [7:0] d;
        logic [6:0] ac;
        logic [6:0] mode;
    } vec_t;

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h",
                     nm, act, exp);
        end
    endtask

    task automatic xfer(input logic rs, input logic rw,
                        input logic [7:0] d, input int hi,
                        input int gap, output logic [7:0] q);
        @(negedge clk);
        lcd_rs = rs; lcd_rw = rw; lcd_data = d; lcd_e = 1'b1;
        repeat (hi) @(negedge clk);
        q = lcd_dout;
        lcd_e = 1'b0;
        repeat (gap) @(negedge clk);
        lcd_rw = 1'b0;
    endtask

    task automatic wr(input logic rs, input logic [7:0] d);
        logic [7:0] q;
        xfer(rs, 1'b0, d, 3, 20, q);
    endtask

    task automatic rd(input logic rs, output logic [7:0] q);
        xfer(rs, 1'b1, 8'h00, 5, 20, q);
    endtask

    task automatic rdc(input logic r, input int c,
                       output logic [7:0] q);
        rd_row = r; rd_col = 4'(c);
        #1;
        q = rd_char;
    endtask

    function automatic logic [25:0] outs();
        return {lcd_dout, busy, ac, disp_on, cursor_on,
                blink_on, entry_id, entry_s, two_line, dl8,
                wr_strobe, err_busy, err_early};
    endfunction

    function automatic logic [6:0] mode();
        return {disp_on, cursor_on, blink_on, entry_id,
                entry_s, two_line, dl8};
    endfunction

    // linear model: position 0..79 = row*40 + col
    function automatic logic [6:0] p2a(input int p);
        return (p < 40) ? 7'(p) : 7'(64 + p - 40);
    endfunction

    localparam logic [25:0] RST_OUTS =
        {8'h00, 1'b0, 7'h00, 3'b000, 1'b1, 1'b0,
         1'b0, 1'b1, 3'b000};

    logic [7:0] mem [80];
    int m_pos, m_off;
    bit m_id, m_s;

    initial begin
        vec_t       tbl [12];
        logic [7:0] q;
        logic [7:0] seoul [5];
        logic [7:0] bell [8];
        int         s0;

        tbl[0]  = '{1'b0, 8'h28, 7'h00, 7'b0001010};
        tbl[1]  = '{1'b0, 8'h38, 7'h00, 7'b0001011};
        tbl[2]  = '{1'b0, 8'h0F, 7'h00, 7'b1111011};
        tbl[3]  = '{1'b0, 8'h0C, 7'h00, 7'b1001011};
        tbl[4]  = '{1'b0, 8'h01, 7'h00, 7'b1001011};
        tbl[5]  = '{1'b0, 8'h06, 7'h00, 7'b1001011};
        tbl[6]  = '{1'b0, 8'h80, 7'h00, 7'b1001011};
        tbl[7]  = '{1'b1, 8'h53, 7'h01, 7'b1001011};
        tbl[8]  = '{1'b1, 8'h45, 7'h02, 7'b1001011};
        tbl[9]  = '{1'b1, 8'h4F, 7'h03, 7'b1001011};
        tbl[10] = '{1'b1, 8'h55, 7'h04, 7'b1001011};
        tbl[11] = '{1'b1, 8'h4C, 7'h05, 7'b1001011};
        seoul = '{8'h53, 8'h45, 8'h4F, 8'h55, 8'h4C};
        bell  = '{8'h04, 8'h0E, 8'h0E, 8'h0E,
                  8'h0E, 8'h1F, 8'h04, 8'h00};

        rst = 1'b1; lcd_rs = 0; lcd_rw = 0; lcd_e = 0;
        lcd_data = '0; rd_row = 0; rd_col = '0;
        repeat (4) @(negedge clk);
        chk("reset_outs_in_rst", 26'(outs()), 26'(RST_OUTS));
        rst = 1'b0;
        @(negedge clk);
        chk("reset_outs", 26'(outs()), 26'(RST_OUTS));

        // power-on window
        repeat (95) @(negedge clk);
        wr(1'b0, 8'h38);
        chk("early_err", err_early, 1);
        chk("early_ignored", two_line, 0);
        chk("early_not_busy_err", err_busy, 0);
        repeat (500) @(negedge clk);
        wr(1'b0, 8'h38);
        chk("pon_two_line", two_line, 1);
        chk("early_sticky", err_early, 1);

        s0 = strobes;
        for (int i = 0; i < 12; i++) begin
            wr(tbl[i].rs, tbl[i].d);
            chk($sformatf("tbl%0d_ac", i), ac, tbl[i].ac);
            chk($sformatf("tbl%0d_mode", i), mode(), tbl[i].mode);
        end
        chk("seoul_strobes", strobes - s0, 5);
        for (int c = 0; c < 5; c++) begin
            rdc(1'b0, c, q);
            chk($sformatf("seoul_c%0d", c), q, seoul[c]);
        end

        // two-line wrap points
        wr(0, 8'hA7); wr(1, 8'h41); wr(1, 8'h42);
        chk("wrap_ac_up", ac, 7'h41);
        wr(0, 8'hA7); rd(1, q);
        chk("wrap_rd27", q, 8'h41);
        chk("wrap_rd_ac", ac, 7'h40);
        rd(1, q);
        chk("wrap_rd40", q, 8'h42);
        wr(0, 8'h04); wr(0, 8'h80); wr(1, 8'h5A);
        chk("wrap_ac_dn00", ac, 7'h67);
        wr(0, 8'hC0); wr(1, 8'h33);
        chk("wrap_ac_dn40", ac, 7'h27);
        wr(0, 8'h06);

        // CGRAM: upper three bits are dropped
        wr(0, 8'h40);
        for (int i = 0; i < 8; i++)
            wr(1, bell[i] | {3'($urandom_range(0, 7)), 5'b0});
        chk("cg_ac", ac, 7'h08);
        wr(0, 8'h40);
        for (int i = 0; i < 8; i++) begin
            rd(1, q);
            chk($sformatf("cg_rd%0d", i), q, bell[i]);
        end
        wr(0, 8'h7F);
        chk("cg_ac3f", ac, 7'h3F);
        wr(1, 8'h1F);
        chk("cg_wrap_up", ac, 7'h00);
        wr(0, 8'h04); wr(1, 8'h00);
        chk("cg_wrap_dn", ac, 7'h3F);
        wr(0, 8'h06); wr(0, 8'h80); wr(1, 8'h00);
        rdc(1'b0, 0, q);
        chk("cg_char0", q, 8'h00);

        // busy violations
        chk("no_busy_err_yet", err_busy, 0);
        xfer(0, 0, 8'h01, 2, 3, q);
        xfer(1, 0, 8'h6B, 2, 20, q);
        chk("busy_err", err_busy, 1);
        rdc(1'b0, 0, q);
        chk("busy_data_at0", q, 8'h6B);
        rdc(1'b0, 1, q);
        chk("busy_clear_done", q, 8'h20);
        chk("busy_ac", ac, 7'h01);
        xfer(0, 0, 8'h01, 2, 1, q);
        xfer(0, 1, 8'h00, 6, 20, q);
        chk("status_busy", q, 8'h80);

        // random traffic against the linear model
        wr(0, 8'h01); wr(0, 8'h06); wr(0, 8'h0C);
        for (int i = 0; i < 80; i++) mem[i] = 8'h20;
        m_pos = 0; m_off = 0; m_id = 1; m_s = 0;
        for (int k = 0; k < 80; k++) begin
            int op;
            logic [7:0] d;
            bit b1, b2;
            op = $urandom_range(0, 5);
            b1 = 1'($urandom_range(0, 1));
            b2 = 1'($urandom_range(0, 1));
            case (op)
                0: begin
                    m_pos = $urandom_range(0, 79);
                    wr(0, {1'b1, p2a(m_pos)});
                end
                1: begin
                    d = 8'($urandom_range(33, 126));
                    wr(1, d);
                    mem[m_pos] = d;
                    if (m_s) m_off = (m_off + (m_id ? 1 : 39)) % 40;
                    m_pos = (m_pos + (m_id ? 1 : 79)) % 80;
                end
                2: begin
                    wr(0, {6'b000001, b1, b2});
                    m_id = b1; m_s = b2;
                end
                3: begin
                    wr(0, {4'b0001, b1, b2, 2'b00});
                    if (b1) m_off = (m_off + (b2 ? 39 : 1)) % 40;
                    else    m_pos = (m_pos + (b2 ? 1 : 79)) % 80;
                end
                4: begin
                    rd(1, q);
                    chk($sformatf("rnd%0d_data", k), q, mem[m_pos]);
                    m_pos = (m_pos + (m_id ? 1 : 79)) % 80;
                end
                default: begin
                    rd(0, q);
                    chk($sformatf("rnd%0d_stat", k), q,
                        {1'b0, p2a(m_pos)});
                end
            endcase
            chk($sformatf("rnd%0d_ac", k), ac, p2a(m_pos));
        end
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 16; c++) begin
                rdc(1'(r), c, q);
                chk($sformatf("rnd_view_r%0dc%0d", r, c), q,
                    mem[r * 40 + (c + m_off) % 40]);
            end

        // reset during a data write with e high
        s0 = strobes;
        @(negedge clk);
        lcd_rs = 1; lcd_rw = 0; lcd_data = 8'h77; lcd_e = 1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        lcd_e = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_mid_outs", 26'(outs()), 26'(RST_OUTS));
        rst = 1'b0;
        @(negedge clk);
        chk("rst_rel_outs", 26'(outs()), 26'(RST_OUTS));
        repeat (600) @(negedge clk);
        wr(0, 8'h38); wr(0, 8'h0C);
        chk("rst_no_strobe", strobes - s0, 0);
        chk("rst_no_early", err_early, 0);
        chk("rst_ac", ac, 7'h00);
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 16; c++) begin
                rdc(1'(r), c, q);
                chk($sformatf("rst_fill_r%0dc%0d", r, c), q, 8'h20);
            end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
